// File: rtl/store_lane_unit.sv
// store_lane_unit
//   Store-path lane aligner and write buffer for the or1420 data-memory
//   interface. CPU stores (byte / half-word / word) are checked for
//   alignment, steered onto big-endian byte lanes, queued in a small FIFO
//   and issued one at a time with a request/grant/done bus handshake.
//
// Ports
//   clock, nReset         : clock, asynchronous active-low reset
//   storeValid/storeReady : store request handshake (ready = FIFO not full)
//   storeSize             : 00 byte, 01 half-word, 10 word, 11 reserved
//   storeAddress          : byte address of the store
//   storeData             : right-justified store data
//   misalignedError       : one-cycle pulse after a rejected store
//   busRequest            : transaction pending (REQUEST state)
//   busGrant              : single-cycle grant from the arbiter
//   busAddress            : word address of the FIFO head
//   busByteEnables        : lane enables, bit 3 = lane 31:24
//   busData               : lane-aligned data of the FIFO head
//   busDone               : single-cycle completion of the granted transaction
//   busy                  : FIFO non-empty or FSM not idle
module store_lane_unit #(
    parameter int unsigned DEPTH = 2
) (
    input  logic        clock,
    input  logic        nReset,
    input  logic        storeValid,
    output logic        storeReady,
    input  logic [1:0]  storeSize,
    input  logic [31:0] storeAddress,
    input  logic [31:0] storeData,
    output logic        misalignedError,
    output logic        busRequest,
    input  logic        busGrant,
    output logic [31:0] busAddress,
    output logic [3:0]  busByteEnables,
    output logic [31:0] busData,
    input  logic        busDone,
    output logic        busy
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL = (PW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQUEST,
        S_WAIT
    } state_t;

    state_t state, state_next;

    logic [29:0] mem_addr [DEPTH];
    logic [3:0]  mem_be   [DEPTH];
    logic [31:0] mem_data [DEPTH];

    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [PW:0]   count;

    logic [3:0]  align_be;
    logic [31:0] align_data;
    logic        align_mis;
    logic        accept, push, pop, head_valid;

    // Big-endian lane steering: address offset 0 lands on lane 31:24.
    always_comb begin
        align_be   = '0;
        align_data = '0;
        align_mis  = 1'b0;
        case (storeSize)
            2'b00: begin
                align_be   = 4'b1000 >> storeAddress[1:0];
                align_data = {4{storeData[7:0]}};
            end
            2'b01: begin
                align_be   = storeAddress[1] ? 4'b0011 : 4'b1100;
                align_data = {2{storeData[15:0]}};
                align_mis  = storeAddress[0];
            end
            2'b10: begin
                align_be   = '1;
                align_data = storeData;
                align_mis  = (storeAddress[1:0] != 2'b00);
            end
            default: align_mis = 1'b1;
        endcase
    end

    assign storeReady = (count != FULL);
    assign accept     = storeValid & storeReady;
    // Misaligned requests are consumed but never enter the FIFO.
    assign push       = accept & ~align_mis;
    assign pop        = (state == S_WAIT) & busDone;
    assign head_valid = (count != '0);

    always_ff @(posedge clock) begin
        if (push) begin
            mem_addr[wr_ptr] <= storeAddress[31:2];
            mem_be[wr_ptr]   <= align_be;
            mem_data[wr_ptr] <= align_data;
        end
    end

    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            rd_ptr          <= '0;
            wr_ptr          <= '0;
            count           <= '0;
            misalignedError <= 1'b0;
        end else begin
            misalignedError <= accept & align_mis;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // State register
    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) state <= S_IDLE;
        else         state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:    if (head_valid) state_next = S_REQUEST;
            S_REQUEST: if (busGrant)   state_next = S_WAIT;
            S_WAIT: begin
                // Decision uses the pre-pop count so a queued entry
                // re-requests immediately after busDone.
                if (busDone) state_next = (count > (PW + 1)'(1)) ? S_REQUEST : S_IDLE;
            end
            default:   state_next = S_IDLE;
        endcase
    end

    // Outputs; head fields read as zero whenever the FIFO is empty,
    // which also covers the reset condition.
    always_comb begin
        busRequest     = (state == S_REQUEST);
        busy           = head_valid | (state != S_IDLE);
        busAddress     = '0;
        busByteEnables = '0;
        busData        = '0;
        if (head_valid) begin
            busAddress     = {mem_addr[rd_ptr], 2'b00};
            busByteEnables = mem_be[rd_ptr];
            busData        = mem_data[rd_ptr];
        end
    end

endmodule

// File: tb/tb_store_lane_unit.sv
module tb_store_lane_unit;

    localparam int unsigned DEPTH = 4;

    logic        clock = 1'b0;
    logic        nReset = 1'b0;
    logic        storeValid = 1'b0;
    logic        storeReady;
    logic [1:0]  storeSize = '0;
    logic [31:0] storeAddress = '0;
    logic [31:0] storeData = '0;
    logic        misalignedError;
    logic        busRequest;
    logic        busGrant = 1'b0;
    logic [31:0] busAddress;
    logic [3:0]  busByteEnables;
    logic [31:0] busData;
    logic        busDone = 1'b0;
    logic        busy;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [31:0] a;
        logic [3:0]  be;
        logic [31:0] d;
    } ent_t;

    ent_t expq[$];

    store_lane_unit #(.DEPTH(DEPTH)) dut (
        .clock(clock), .nReset(nReset),
        .storeValid(storeValid), .storeReady(storeReady),
        .storeSize(storeSize), .storeAddress(storeAddress), .storeData(storeData),
        .misalignedError(misalignedError),
        .busRequest(busRequest), .busGrant(busGrant),
        .busAddress(busAddress), .busByteEnables(busByteEnables), .busData(busData),
        .busDone(busDone), .busy(busy)
    );

    always #5 clock = ~clock;

    // Reference: an n-byte store covers byte offsets [off, off+n) of the
    // word; offset k is lane 3-k and holds the big-endian byte k mod n of d.
    function automatic void ref_store(input logic [1:0] sz, input logic [31:0] a,
                                      input logic [31:0] d, output bit mis, output ent_t e);
        int n, off;
        n   = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        off = int'(a % 4);
        mis = (sz == 2'd3) || ((off % n) != 0);
        e.a  = a - 32'(off);
        e.be = '0;
        e.d  = '0;
        for (int k = 0; k < 4; k++) begin
            e.d[(3-k)*8 +: 8] = d[(n-1-(k % n))*8 +: 8];
            e.be[3-k]         = (k >= off) && (k < off + n);
        end
    endfunction

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic do_store(input logic [1:0] sz, input logic [31:0] a,
                            input logic [31:0] d, output bit ok);
        int n = 0;
        ok = 1'b0;
        while (!storeReady && n < 50) begin @(negedge clock); n++; end
        if (storeReady) begin
            storeValid = 1'b1; storeSize = sz; storeAddress = a; storeData = d;
            @(negedge clock);
            storeValid = 1'b0;
            ok = 1'b1;
        end
    endtask

    // Waits for a request, captures the presented entry, grants, completes.
    task automatic serve(output bit ok, output ent_t e);
        int n = 0;
        ok = 1'b0;
        e  = '0;
        while (!busRequest && n < 50) begin @(negedge clock); n++; end
        if (busRequest) begin
            e = {busAddress, busByteEnables, busData};
            busGrant = 1'b1;
            @(negedge clock);
            busGrant = 1'b0;
            busDone  = 1'b1;
            @(negedge clock);
            busDone  = 1'b0;
            ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        #1;
        total++; if (storeReady !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", storeReady); end
        total++; if (busRequest !== 1'b0) begin bad++; $display("FAIL reset_req got=%b want=0", busRequest); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (misalignedError !== 1'b0) begin bad++; $display("FAIL reset_mis got=%b want=0", misalignedError); end
        total++; if ({busAddress, busByteEnables, busData} !== 68'h0) begin
            bad++; $display("FAIL reset_bus got=%h/%b/%h want=0", busAddress, busByteEnables, busData); end
        @(negedge clock);
        nReset = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_aligned_directed();
        logic [1:0]  sz [6] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd2};
        logic [31:0] ad [6] = '{32'h100, 32'h101, 32'h102, 32'h103, 32'h202, 32'h300};
        logic [31:0] dd [6] = '{32'hA5, 32'hA5, 32'hA5, 32'hA5, 32'h1234, 32'hDEADBEEF};
        bit ok, mis;
        ent_t e, got;
        for (int i = 0; i < 6; i++) begin
            ref_store(sz[i], ad[i], dd[i], mis, e);
            do_store(sz[i], ad[i], dd[i], ok);
            total++; if (ok !== 1'b1) begin bad++; $display("FAIL dir_accept[%0d] timeout", i); end
            total++; if (misalignedError !== 1'b0) begin bad++; $display("FAIL dir_mis[%0d] got=%b want=0", i, misalignedError); end
            if (i == 0) begin
                total++; if (busRequest !== 1'b0) begin bad++; $display("FAIL latency_early got=%b want=0", busRequest); end
                @(negedge clock);
                total++; if (busRequest !== 1'b1) begin bad++; $display("FAIL latency_req got=%b want=1", busRequest); end
            end
            serve(ok, got);
            total++; if (ok !== 1'b1 || got !== e) begin
                bad++; $display("FAIL dir_entry[%0d] got=%h want=%h", i, got, e); end
            total++; if (busy !== 1'b0) begin bad++; $display("FAIL dir_idle[%0d] got=%b want=0", i, busy); end
        end
    endtask

    task automatic test_misaligned();
        logic [1:0]  sz [3] = '{2'd1, 2'd2, 2'd3};
        logic [31:0] ad [3] = '{32'h201, 32'h302, 32'h400};
        bit ok, mis;
        ent_t e;
        for (int i = 0; i < 3; i++) begin
            ref_store(sz[i], ad[i], 32'h5555AAAA, mis, e);
            do_store(sz[i], ad[i], 32'h5555AAAA, ok);
            total++; if (misalignedError !== mis) begin bad++; $display("FAIL mis_pulse[%0d] got=%b want=%b", i, misalignedError, mis); end
            total++; if (busy !== 1'b0) begin bad++; $display("FAIL mis_busy[%0d] got=%b want=0", i, busy); end
            @(negedge clock);
            total++; if (misalignedError !== 1'b0) begin bad++; $display("FAIL mis_width[%0d] got=%b want=0", i, misalignedError); end
            total++; if (busRequest !== 1'b0 || busy !== 1'b0) begin
                bad++; $display("FAIL mis_noreq[%0d] got=%b%b want=00", i, busRequest, busy); end
        end
    endtask

    task automatic test_fill_drain();
        bit ok, mis;
        ent_t e, got;
        logic [1:0] sz;
        logic [31:0] a;
        for (int i = 0; i < int'(DEPTH); i++) begin
            sz = 2'($urandom_range(0, 2));
            a  = $urandom & ~((32'd1 << sz) - 32'd1);
            ref_store(sz, a, $urandom, mis, e);
            do_store(sz, a, e.d, ok);
            ref_store(sz, a, e.d, mis, e);
            expq.push_back(e);
        end
        total++; if (storeReady !== 1'b0) begin bad++; $display("FAIL full_ready got=%b want=0", storeReady); end
        repeat (3) @(negedge clock);
        total++; if ({busAddress, busByteEnables, busData} !== expq[0]) begin
            bad++; $display("FAIL full_head got=%h want=%h", {busAddress, busByteEnables, busData}, expq[0]); end
        for (int i = 0; i < int'(DEPTH); i++) begin
            serve(ok, got);
            e = expq.pop_front();
            total++; if (ok !== 1'b1 || got !== e) begin bad++; $display("FAIL drain[%0d] got=%h want=%h", i, got, e); end
            total++; if (storeReady !== 1'b1) begin bad++; $display("FAIL drain_ready[%0d] got=%b want=1", i, storeReady); end
            if (expq.size() > 0) begin
                total++; if (busRequest !== 1'b1) begin bad++; $display("FAIL b2b_req[%0d] got=%b want=1", i, busRequest); end
            end
        end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL drain_busy got=%b want=0", busy); end
    endtask

    task automatic test_push_on_done();
        bit ok, mis;
        ent_t ea, eb, got;
        int n = 0;
        ref_store(2'd2, 32'h0000_1000, 32'h11223344, mis, ea);
        ref_store(2'd1, 32'h0000_2006, 32'h0000CAFE, mis, eb);
        do_store(2'd2, 32'h0000_1000, 32'h11223344, ok);
        while (!busRequest && n < 50) begin @(negedge clock); n++; end
        total++; if ({busAddress, busByteEnables, busData} !== ea) begin
            bad++; $display("FAIL pod_head got=%h want=%h", {busAddress, busByteEnables, busData}, ea); end
        busGrant = 1'b1;
        @(negedge clock);
        busGrant = 1'b0;
        busDone = 1'b1;
        storeValid = 1'b1; storeSize = 2'd1; storeAddress = 32'h0000_2006; storeData = 32'h0000CAFE;
        @(negedge clock);
        busDone = 1'b0; storeValid = 1'b0;
        total++; if (busy !== 1'b1 || busRequest !== 1'b0) begin
            bad++; $display("FAIL pod_state got=%b%b want=10", busy, busRequest); end
        serve(ok, got);
        total++; if (ok !== 1'b1 || got !== eb) begin bad++; $display("FAIL pod_next got=%h want=%h", got, eb); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL pod_count got=%b want=0", busy); end
    endtask

    task automatic test_reset_midflight();
        bit ok, mis;
        ent_t e, got;
        int n = 0;
        do_store(2'd2, 32'h0000_4000, 32'hAAAA0001, ok);
        do_store(2'd2, 32'h0000_4004, 32'hAAAA0002, ok);
        while (!busRequest && n < 50) begin @(negedge clock); n++; end
        busGrant = 1'b1;
        @(negedge clock);
        busGrant = 1'b0;
        total++; if (busy !== 1'b1 || busRequest !== 1'b0) begin
            bad++; $display("FAIL rst_pre got=%b%b want=10", busy, busRequest); end
        nReset = 1'b0;
        #1;
        total++; if (busRequest !== 1'b0 || busy !== 1'b0 || storeReady !== 1'b1) begin
            bad++; $display("FAIL rst_async got=%b%b%b want=001", busRequest, busy, storeReady); end
        total++; if ({busAddress, busByteEnables, busData} !== 68'h0) begin
            bad++; $display("FAIL rst_bus got=%h want=0", {busAddress, busByteEnables, busData}); end
        @(negedge clock);
        nReset = 1'b1;
        busDone = 1'b1;
        @(negedge clock);
        busDone = 1'b0;
        total++; if (busy !== 1'b0 || busRequest !== 1'b0) begin
            bad++; $display("FAIL rst_latedone got=%b%b want=00", busy, busRequest); end
        ref_store(2'd0, 32'h0000_5003, 32'h0000007E, mis, e);
        do_store(2'd0, 32'h0000_5003, 32'h0000007E, ok);
        serve(ok, got);
        total++; if (ok !== 1'b1 || got !== e) begin bad++; $display("FAIL rst_after got=%h want=%h", got, e); end
    endtask

    task automatic test_random();
        bit ok, mis;
        ent_t e, got;
        logic [1:0] sz;
        logic [31:0] a, d;
        for (int r = 0; r < 12; r++) begin
            for (int k = 0; k < int'(DEPTH) + 2 && expq.size() < int'(DEPTH); k++) begin
                sz = 2'($urandom_range(0, 3));
                a  = $urandom;
                d  = $urandom;
                ref_store(sz, a, d, mis, e);
                do_store(sz, a, d, ok);
                total++; if (ok !== 1'b1 || misalignedError !== mis) begin
                    bad++; $display("FAIL rnd_mis[%0d.%0d] got=%b want=%b", r, k, misalignedError, mis); end
                if (!mis) expq.push_back(e);
            end
            while (expq.size() > 0) begin
                repeat ($urandom_range(0, 2)) @(negedge clock);
                serve(ok, got);
                e = expq.pop_front();
                total++; if (ok !== 1'b1 || got !== e) begin bad++; $display("FAIL rnd_entry[%0d] got=%h want=%h", r, got, e); end
            end
            total++; if (busy !== 1'b0) begin bad++; $display("FAIL rnd_idle[%0d] got=%b want=0", r, busy); end
        end
    endtask

    initial begin
        test_reset();
        test_aligned_directed();
        test_misaligned();
        test_fill_drain();
        test_push_on_done();
        test_reset_midflight();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout total=%0d", total);
        $fatal(1);
    end

endmodule

// File: doc/store_lane_unit.md
# store_lane_unit

Store-path lane aligner and write buffer for the or1420 data-memory interface. It accepts CPU store requests of byte, half-word or word size, rejects misaligned ones, and places the data on the correct big-endian byte lanes with matching byte enables. It queues aligned stores in a small FIFO and issues them one at a time to the bus with a request/grant/done handshake. It is the write-direction counterpart of the load-side sign/zero-extension path in the execute stage.

## Interface
- `DEPTH`, default 2: FIFO entries. Must be a power of 2 and at least 2.
- `clock` in 1: single clock. All state changes on its rising edge.
- `nReset` in 1: asynchronous, active-low reset.
- `storeValid` in 1: a store request is present.
- `storeReady` out 1: the unit can accept a request, equal to FIFO not full.
- `storeSize` in 2: `00` byte, `01` half-word, `10` word, `11` reserved.
- `storeAddress` in 32: byte address of the store.
- `storeData` in 32: store data, right-justified.
- `misalignedError` out 1: one-cycle pulse when a store is rejected.
- `busRequest` out 1: a transaction is pending.
- `busGrant` in 1: single-cycle grant from the arbiter.
- `busAddress` out 32: word address of the FIFO head, `{addr[31:2],2'b00}`.
- `busByteEnables` out 4: lane enables. Bit 3 is lane 31:24.
- `busData` out 32: lane-aligned data.
- `busDone` in 1: single-cycle completion of the granted transaction.
- `busy` out 1: FIFO non-empty or FSM not IDLE.

## Operation
- A request is accepted on an edge where `storeValid & storeReady` is high.
- Alignment is big-endian: address offset 0 maps to lane 31:24.
  - Byte: enables = `4'b1000 >> addr[1:0]`; data = `{4{d[7:0]}}`.
  - Half-word: `addr[1]=0` gives enables `1100`, `addr[1]=1` gives `0011`; data = `{2{d[15:0]}}`.
  - Word: enables `1111`; data = `d`.
- Misalignment is any of:
  - a half-word with `addr[0]=1`;
  - a word with `addr[1:0]!=00`;
  - size `11`.
- A misaligned request is still consumed. It is not written to the FIFO, and `misalignedError` is high for the cycle after the accepting edge.
- The FIFO stores the aligned word address, enables and data. It has a read pointer, a write pointer and a count, and the pointers wrap modulo `DEPTH`.
- FSM states:
  - IDLE: if the FIFO is non-empty, go to REQUEST.
  - REQUEST: `busRequest=1`. On `busGrant`, go to WAIT. `busDone` is ignored in this state.
  - WAIT: `busRequest=0`. On `busDone`, pop the head. If the pre-pop count is above 1, go to REQUEST; otherwise go to IDLE. `busGrant` is ignored in this state.
- `busAddress`, `busByteEnables` and `busData` always reflect the FIFO head. They stay stable from entry to REQUEST until the `busDone` edge.
- Push and pop on the same edge: both happen and the count is unchanged. A push while full cannot occur because `storeReady=0`.
- A misaligned request arriving while the FIFO is full waits for `storeReady` like any other request.

## Timing
- While `nReset=0` the following hold; all are asynchronous and take effect immediately, including mid-transaction:
  - FIFO empty, pointers 0, FSM in IDLE.
  - `busRequest=0`, `misalignedError=0`, `busy=0`.
  - `storeReady=1`.
  - `busAddress`, `busByteEnables` and `busData` are 0.
- An in-flight bus transaction is abandoned on reset; `busDone` arriving after reset is ignored.
- Latency from acceptance to request: a request accepted on edge E into an empty, idle unit raises `busRequest` after edge E+1.
- Back-to-back stores: `busDone` on edge D with another entry queued makes `busRequest` high again after D with no idle cycle.
- `storeReady` is combinational from the count. It rises in the cycle after the edge that pops the entry from a full FIFO.
- `misalignedError` is registered: high for exactly one cycle per rejected request.
- `busy` is combinational from state and count.

## Test plan
- Byte stores of `0xA5` to addresses `0x100`, `0x101`, `0x102` and `0x103` must produce:
  - enables `1000`, `0100`, `0010`, `0001`;
  - `busData=0xA5A5A5A5` each time;
  - `busAddress=0x100` each time.
- Half-word store of `0x1234` to `0x202` -> enables `0011`, `busData=0x12341234`, `busAddress=0x200`. Word store of `0xDEADBEEF` to `0x300` -> enables `1111`.
- Half-word to `0x201`, word to `0x302`, and size `11` -> each gets `misalignedError` for one cycle, no `busRequest`, and `busy` stays 0.
- Fill with `DEPTH` stores while `busGrant` is held low -> `storeReady=0`, and outputs stay on the first entry. Grant and complete each one -> stores leave in FIFO order, `busRequest` re-asserts right after each `busDone`, and `storeReady` returns to 1.
- Push on the same edge as `busDone` with one entry queued -> count unchanged, and the next request presents the new entry.
- Assert `nReset` low while in WAIT with 2 entries queued -> `busRequest=0` and `busy=0` immediately. After release, a late `busDone` has no effect and a new store issues normally.
